anode_scan_decoder: RTL and testbench

- Time-multiplexed digit scanner for multi-digit 7-segment displays: a prescaled counter steps a digit index, and a parametrised one-hot decoder turns the index into anode enables.
- Sits between the board clock and the segment-pattern logic. digit_sel tells the segment mux which digit value to drive, aligned with anode.
- Generalises the fixed 3-to-8 decoder: parametrised width, non-power-of-two digit counts, polarity, per-digit blanking, enable and frame pulse.

---
 rtl/scan_pkg.sv | 30 +++
 rtl/onehot_decoder_n.sv | 24 ++
 rtl/anode_scan_decoder.sv | 95 +++++++++
 tb/tb_anode_scan_decoder.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared constants and helpers for the anode scanner
//
// Purpose: anode polarity helper, prescaler width helper and a generic
//          index-to-one-hot function used by the decoder.
// Ports:   none (package).
package scan_pkg;

   // Widest one-hot vector the helper can produce.
   localparam int MAX_OUTS = 256;

   // Drive level for an anode: on=1 gives the active level for the polarity.
   function automatic logic anode_level(input logic active_low, input logic on);
      return on ^ active_low;
   endfunction

   // Prescaler width; never below 1 so a PRESCALE of 1 or 2 still has a register.
   function automatic int clog2_min1(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

   // One-hot of idx; all zeros when idx falls outside 0..width-1.
   function automatic logic [MAX_OUTS-1:0] onehot(input int idx, input int width);
      logic [MAX_OUTS-1:0] r;
      for (int i = 0; i < MAX_OUTS; i++) begin
         r[i] = (i < width) && (i == idx);
      end
      return r;
   endfunction

endpackage

// File: rtl/onehot_decoder_n.sv
// rtl/onehot_decoder_n.sv - combinational index to one-hot decoder with enable
//
// Purpose: decodes an N-bit index into OUTS one-hot lines.
// Ports:   idx        in  N     index to decode
//          enable     in  1     0 forces all outputs low
//          onehot_out out OUTS  one-hot result, zero for idx >= OUTS
module onehot_decoder_n #(
   parameter int N    = 3,
   parameter int OUTS = 8
) (
   input  logic [N-1:0]    idx,
   input  logic            enable,
   output logic [OUTS-1:0] onehot_out
);
   import scan_pkg::*;

   always_comb begin
      onehot_out = '0;
      if (enable) begin
         onehot_out = OUTS'(onehot(32'(idx), OUTS));
      end
   end

endmodule

// File: rtl/anode_scan_decoder.sv
// rtl/anode_scan_decoder.sv - time-multiplexed 7-segment digit scanner
//
// Purpose: a prescaler steps a digit index every PRESCALE enabled cycles;
//          the next index is decoded, masked and driven onto the anodes.
// Ports:   clk        in  1           rising-edge clock
//          reset      in  1           synchronous active-high reset
//          enable     in  1           1 scans, 0 freezes and blanks
//          digit_mask in  NUM_DIGITS  bit i blanks digit i
//          anode      out NUM_DIGITS  registered anode enables
//          digit_sel  out N           registered current digit index
//          frame_done out 1           one-cycle pulse on wrap to digit 0
module anode_scan_decoder #(
   parameter int N          = 3,
   parameter int NUM_DIGITS = 8,
   parameter int PRESCALE   = 100000,
   parameter int ACTIVE_LOW = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [NUM_DIGITS-1:0] digit_mask,
   output logic [NUM_DIGITS-1:0] anode,
   output logic [N-1:0]          digit_sel,
   output logic                  frame_done
);
   import scan_pkg::*;

   if (NUM_DIGITS < 1 || NUM_DIGITS > (1 << N)) begin : g_bad_digits
      $error("anode_scan_decoder: NUM_DIGITS must be in 1..2**N");
   end
   if (PRESCALE < 1) begin : g_bad_prescale
      $error("anode_scan_decoder: PRESCALE must be >= 1");
   end

   localparam int             PW        = clog2_min1(PRESCALE);
   localparam logic [PW-1:0]  PRE_LAST  = PW'(PRESCALE - 1);
   localparam logic [N-1:0]   IDX_LAST  = N'(NUM_DIGITS - 1);
   localparam logic           ANODE_ON  = anode_level(ACTIVE_LOW != 0, 1'b1);
   localparam logic           ANODE_OFF = anode_level(ACTIVE_LOW != 0, 1'b0);

   logic [PW-1:0]         pre;
   logic [N-1:0]          idx;
   logic [N-1:0]          idx_next;
   logic                  step;
   logic                  wrap;
   logic [NUM_DIGITS-1:0] dec;
   logic [NUM_DIGITS-1:0] lit;

   assign step = (pre == PRE_LAST);
   assign wrap = step && (idx == IDX_LAST);

   // Wrap explicitly at NUM_DIGITS-1 so non-power-of-two counts never
   // reach the unused upper index values.
   always_comb begin
      idx_next = idx;
      if (wrap) begin
         idx_next = '0;
      end else if (step) begin
         idx_next = idx + 1'b1;
      end
   end

   // Decoding idx_next lets anode and digit_sel change on the same edge.
   onehot_decoder_n #(
      .N    (N),
      .OUTS (NUM_DIGITS)
   ) u_dec (
      .idx        (idx_next),
      .enable     (enable),
      .onehot_out (dec)
   );

   assign lit = dec & ~digit_mask;

   always_ff @(posedge clk) begin
      if (reset) begin
         pre        <= '0;
         idx        <= '0;
         anode      <= {NUM_DIGITS{ANODE_OFF}};
         frame_done <= 1'b0;
      end else if (!enable) begin
         anode      <= {NUM_DIGITS{ANODE_OFF}};
         frame_done <= 1'b0;
      end else begin
         pre        <= step ? '0 : pre + 1'b1;
         idx        <= idx_next;
         anode      <= ANODE_ON ? lit : ~lit;
         frame_done <= wrap;
      end
   end

   // idx only ever loads idx_next, so it is the registered digit index.
   assign digit_sel = idx;

endmodule

// File: tb/tb_anode_scan_decoder.sv
// tb/tb_anode_scan_decoder.sv - self-checking bench for anode_scan_decoder
module tb_anode_scan_decoder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       enable;
   logic [4:0] digit_mask;
   logic [4:0] anode;
   logic [2:0] digit_sel;
   logic       frame_done;

   logic       reset8;
   logic       enable8;
   logic [7:0] mask8;
   logic [7:0] anode8;
   logic [2:0] sel8;
   logic       fd8;

   anode_scan_decoder #(
      .N(3), .NUM_DIGITS(5), .PRESCALE(4), .ACTIVE_LOW(1)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .digit_mask (digit_mask),
      .anode      (anode),
      .digit_sel  (digit_sel),
      .frame_done (frame_done)
   );

   anode_scan_decoder #(
      .N(3), .NUM_DIGITS(8), .PRESCALE(1), .ACTIVE_LOW(0)
   ) dut8 (
      .clk        (clk),
      .reset      (reset8),
      .enable     (enable8),
      .digit_mask (mask8),
      .anode      (anode8),
      .digit_sel  (sel8),
      .frame_done (fd8)
   );

   typedef struct {
      logic       rst;
      logic       en;
      logic [4:0] mask;
      logic [4:0] anode;
      logic [2:0] sel;
      logic       fd;
   } vec_t;

   vec_t vecs[$];
   int   total = 0;
   int   bad   = 0;

   task automatic add(input logic r, input logic e, input logic [4:0] m,
                      input logic [4:0] a, input logic [2:0] s, input logic f);
      vec_t v;
      v.rst = r; v.en = e; v.mask = m; v.anode = a; v.sel = s; v.fd = f;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input int row,
                        input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s step %0d: got %0h expected %0h", name, row, act, exp);
      end
   endtask

   initial begin
      reset      = 1'b1;
      enable     = 1'b0;
      digit_mask = '0;
      reset8     = 1'b1;
      enable8    = 1'b0;
      mask8      = '0;

      // reset held with enable high: reset dominates
      repeat (3) add(1, 1, 5'b00000, 5'b11111, 3'd0, 0);
      // free run: first enabled edge shows digit 0
      repeat (3) add(0, 1, 5'b00000, 5'b11110, 3'd0, 0);
      repeat (4) add(0, 1, 5'b00000, 5'b11101, 3'd1, 0);
      repeat (4) add(0, 1, 5'b00000, 5'b11011, 3'd2, 0);
      repeat (4) add(0, 1, 5'b00000, 5'b10111, 3'd3, 0);
      repeat (4) add(0, 1, 5'b00000, 5'b01111, 3'd4, 0);
      add(0, 1, 5'b00000, 5'b11110, 3'd0, 1);
      add(0, 1, 5'b00000, 5'b11110, 3'd0, 0);
      // digit 2 masked for a whole dwell
      repeat (2) add(0, 1, 5'b00100, 5'b11110, 3'd0, 0);
      repeat (4) add(0, 1, 5'b00100, 5'b11101, 3'd1, 0);
      repeat (4) add(0, 1, 5'b00100, 5'b11111, 3'd2, 0);
      add(0, 1, 5'b00100, 5'b10111, 3'd3, 0);
      // mask change inside the digit 3 dwell
      add(0, 1, 5'b01000, 5'b11111, 3'd3, 0);
      add(0, 1, 5'b00000, 5'b10111, 3'd3, 0);
      // freeze at digit 3 with pre = 2
      repeat (10) add(0, 0, 5'b00000, 5'b11111, 3'd3, 0);
      add(0, 1, 5'b00000, 5'b10111, 3'd3, 0);
      add(0, 1, 5'b00000, 5'b01111, 3'd4, 0);
      add(0, 1, 5'b00000, 5'b01111, 3'd4, 0);
      // reset during digit 4 dwell: no frame pulse, full restart
      add(1, 1, 5'b00000, 5'b11111, 3'd0, 0);
      repeat (3) add(0, 1, 5'b00000, 5'b11110, 3'd0, 0);
      add(0, 1, 5'b00000, 5'b11101, 3'd1, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         reset      = vecs[i].rst;
         enable     = vecs[i].en;
         digit_mask = vecs[i].mask;
         @(posedge clk);
         #1;
         check("anode", i, 32'(anode), 32'(vecs[i].anode));
         check("digit_sel", i, 32'(digit_sel), 32'(vecs[i].sel));
         check("frame_done", i, 32'(frame_done), 32'(vecs[i].fd));
      end

      // 8 digits, PRESCALE = 1, active-high: step every cycle
      reset8  = 1'b1;
      enable8 = 1'b1;
      @(posedge clk);
      #1;
      check("dut8 reset anode", 0, 32'(anode8), 32'h00);
      check("dut8 reset sel", 0, 32'(sel8), 32'h0);
      check("dut8 reset fd", 0, 32'(fd8), 32'h0);
      reset8 = 1'b0;
      for (int k = 1; k <= 17; k++) begin
         logic [7:0] ea;
         ea = 8'h01 << (k % 8);
         @(posedge clk);
         #1;
         check("dut8 anode", k, 32'(anode8), 32'(ea));
         check("dut8 sel", k, 32'(sel8), 32'(k % 8));
         check("dut8 fd", k, 32'(fd8), (k % 8 == 0) ? 32'h1 : 32'h0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
